btn_conditioner: RTL and testbench
==================================

# btn_conditioner

Conditions the four raw push-button inputs (BTNU, BTNL, BTNR, BTND) for the square-movement block. It synchronises each input, debounces it with a per-button stable-time counter, and produces clean held levels and one-cycle press pulses. It also produces direction-move levels with opposing-button cancellation. It sits directly upstream of the square animator: `o_up`, `o_left`, `o_right` and `o_down` drive its Up, Left, Right and Down inputs, which it samples on its animation strobe.

## Interface
Parameters:
- `DB_CYCLES`, default 1000000: cycles an input must differ from the stable state before the stable state flips. At 100 MHz this is 10 ms. Legal range is ≥2.
- `CNT_W`, default 20: debounce counter width. It must satisfy 2^CNT_W ≥ DB_CYCLES.

Ports:
- `i_clk`, in, 1: single system clock. Every flop in the block uses it.
- `i_rst_n`, in, 1: asynchronous reset, active-low. It is released synchronously by the board reset logic.
- `i_btn`, in, 4: raw asynchronous buttons. Bit 0 is up, bit 1 left, bit 2 right, bit 3 down. Active-high.
- `o_held`, out, 4: debounced stable level per button, same bit order.
- `o_press`, out, 4: one-cycle pulse on each debounced 0→1 transition.
- `o_release`, out, 4: one-cycle pulse on each debounced 1→0 transition.
- `o_up`, `o_left`, `o_right`, `o_down`, out, 1 each: move levels with cancellation applied.

## Operation
Per button (identical, independent):
- **Synchroniser.** Two flops, `s1 <= i_btn[n]` and `s2 <= s1`. Only `s2` is used downstream.
- **Stable state.** `stable` is the debounced level and drives `o_held[n]`.
- **Counter `cnt`.**
  - If `s2 == stable`, `cnt <= 0`.
  - Otherwise, if `cnt == DB_CYCLES-1`, then `stable <= s2` and `cnt <= 0`.
  - Otherwise, `cnt <= cnt + 1`.
  - `cnt` never wraps. It is bounded by DB_CYCLES-1.
- **Edge detection.** `prev <= stable`. `o_press[n] = stable & ~prev`. `o_release[n] = ~stable & prev`.
- **Bounce rejection.** Any mismatch run shorter than DB_CYCLES cycles clears `cnt` when the input returns to match `stable`, and `stable` is unchanged.

Direction cancellation (combinational from `o_held`):
- `o_up = held[0] & ~held[3]`
- `o_down = held[3] & ~held[0]`
- `o_left = held[1] & ~held[2]`
- `o_right = held[2] & ~held[1]`
- Opposing buttons held together produce no move on that axis. Orthogonal combinations, such as up plus right, pass through.

Reset:
- Assertion of `i_rst_n` clears all flops (`s1`, `s2`, `stable`, `prev`, `cnt`) immediately.
- All outputs are 0 during reset and in the first cycle after release.
- A button already held across reset release is reported as a fresh press after the normal latency.

## Timing
- **Press latency.** Take an input change that is stable from before rising edge k. `o_held` changes after edge k+DB_CYCLES+1, with 2 edges of synchroniser and DB_CYCLES edges of counting (the first counting edge is k+2).
- **Release latency.** Same as press latency.
- **Pulses.** `o_press` and `o_release` are high for exactly the first cycle in which `o_held` shows the new level.
- **Move outputs.** These follow `o_held` in the same cycle, with zero added latency.
- **Simultaneous changes.** Buttons are fully independent. Several buttons may flip, or pulse, in the same cycle.
- **Reset mid-count.** A partially counted change is discarded. Counting restarts from 0 after release.

## Structure
- **Shared package `btn_pkg`** holds:
  - bit index constants `BTN_UP=0`, `BTN_LEFT=1`, `BTN_RIGHT=2`, `BTN_DOWN=3`;
  - `NUM_BTN=4`;
  - default `DB_CYCLES`.
- **Sub-module `btn_debounce`** implements one button: synchroniser, counter, stable, prev, press and release. It is instantiated NUM_BTN times in a generate loop.
- **Top level** contains only the instances and the cancellation logic.

## Test plan
All scenarios run with `DB_CYCLES=4`.
- **Clean press.** Raise `i_btn[0]` before edge 10 → `o_held[0]` and `o_up` rise after edge 15. `o_press[0]` is high for that one cycle only.
- **Bounce.** Toggle `i_btn[1]` high for 3 cycles, low for 1, high for 3, then low → `o_held[1]` stays 0 and `o_press` never pulses.
- **Release.** From `o_held[2]=1`, drop `i_btn[2]` before edge 40 → `o_held[2]` falls after edge 45. `o_release[2]` pulses once and `o_right` goes 0.
- **Cancellation.**
  - Hold up and down both stable → `o_held=4'b1001` and `o_up=o_down=0`.
  - Release down → `o_up=1` after the release latency.
- **Reset mid-count.** Raise `i_btn[3]`, then assert `i_rst_n=0` for 2 cycles after 2 counting edges → outputs are 0 immediately. After release, `o_held[3]` rises exactly 6 edges after reset deassertion.
- **Parallel.** Raise all 4 buttons on the same edge → all `o_held` bits rise together, all `o_press` bits pulse together, and all four move outputs are 0.

Source files
------------

// File: rtl/btn_pkg.sv
// Shared constants for the push-button conditioning path: bit order and debounce defaults.
package btn_pkg;

    localparam int unsigned NUM_BTN   = 4;
    localparam int unsigned BTN_UP    = 0;
    localparam int unsigned BTN_LEFT  = 1;
    localparam int unsigned BTN_RIGHT = 2;
    localparam int unsigned BTN_DOWN  = 3;

    // 10 ms at 100 MHz
    localparam int unsigned DB_CYCLES_DEF = 1000000;
    localparam int unsigned CNT_W_DEF     = 20;

endpackage : btn_pkg

// File: rtl/btn_debounce.sv
// One button: two-flop synchroniser, stable-time debounce counter, and press/release edge pulses.
module btn_debounce
    import btn_pkg::*;
#(
    parameter int unsigned DB_CYCLES = DB_CYCLES_DEF,
    parameter int unsigned CNT_W     = CNT_W_DEF
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_btn,
    output logic o_held,
    output logic o_press,
    output logic o_release
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);

    logic             r_s1;
    logic             r_s2;
    logic             r_stable;
    logic             r_prev;
    logic [CNT_W-1:0] r_cnt;

    // Metastability guard for the raw asynchronous input
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
        end else begin
            r_s1 <= i_btn;
            r_s2 <= r_s1;
        end
    end

    // Stable level flips only after DB_CYCLES consecutive mismatching samples
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_stable <= 1'b0;
            r_cnt    <= '0;
        end else if (r_s2 == r_stable) begin
            r_cnt <= '0;
        end else if (r_cnt == CNT_MAX) begin
            r_stable <= r_s2;
            r_cnt    <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_prev <= 1'b0;
        end else begin
            r_prev <= r_stable;
        end
    end

    assign o_held    = r_stable;
    assign o_press   = r_stable & ~r_prev;
    assign o_release = ~r_stable & r_prev;

endmodule : btn_debounce

// File: rtl/btn_conditioner.sv
// Debounces the four push buttons and derives direction-move levels with opposing-axis cancellation.
module btn_conditioner
    import btn_pkg::*;
#(
    parameter int unsigned DB_CYCLES = DB_CYCLES_DEF,
    parameter int unsigned CNT_W     = CNT_W_DEF
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic [NUM_BTN-1:0] i_btn,
    output logic [NUM_BTN-1:0] o_held,
    output logic [NUM_BTN-1:0] o_press,
    output logic [NUM_BTN-1:0] o_release,
    output logic               o_up,
    output logic               o_left,
    output logic               o_right,
    output logic               o_down
);

    logic [NUM_BTN-1:0] w_held;
    logic [NUM_BTN-1:0] w_press;
    logic [NUM_BTN-1:0] w_release;

    for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
        btn_debounce #(
            .DB_CYCLES (DB_CYCLES),
            .CNT_W     (CNT_W)
        ) u_debounce (
            .i_clk     (i_clk),
            .i_rst_n   (i_rst_n),
            .i_btn     (i_btn[g]),
            .o_held    (w_held[g]),
            .o_press   (w_press[g]),
            .o_release (w_release[g])
        );
    end

    assign o_held    = w_held;
    assign o_press   = w_press;
    assign o_release = w_release;

    // Opposing buttons held together cancel on that axis
    assign o_up    = w_held[BTN_UP]    & ~w_held[BTN_DOWN];
    assign o_down  = w_held[BTN_DOWN]  & ~w_held[BTN_UP];
    assign o_left  = w_held[BTN_LEFT]  & ~w_held[BTN_RIGHT];
    assign o_right = w_held[BTN_RIGHT] & ~w_held[BTN_LEFT];

endmodule : btn_conditioner

// File: tb/tb_btn_conditioner.sv
// Self-checking bench for btn_conditioner: directed scenarios plus random bouncing, against a window-based model.
module tb_btn_conditioner;

    localparam int unsigned DB = 4;

    logic       i_clk;
    logic       i_rst_n;
    logic [3:0] i_btn;
    logic [3:0] o_held;
    logic [3:0] o_press;
    logic [3:0] o_release;
    logic       o_up;
    logic       o_left;
    logic       o_right;
    logic       o_down;

    btn_conditioner #(
        .DB_CYCLES (DB),
        .CNT_W     (3)
    ) dut (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_btn     (i_btn),
        .o_held    (o_held),
        .o_press   (o_press),
        .o_release (o_release),
        .o_up      (o_up),
        .o_left    (o_left),
        .o_right   (o_right),
        .o_down    (o_down)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int n_pass  = 0;
    int n_total = 0;

    // Model: input history per edge since reset release; a level flips once the last DB
    // synchronised samples (input delayed by two edges) all disagree with it since its last flip.
    logic [3:0] hist[$];
    int         e;
    int         last_flip[4];
    logic [3:0] m_stable;
    logic [3:0] m_prev;

    function automatic logic [3:0] s2_seen(int x);
        if (x >= 3) return hist[x-3];
        return 4'b0;
    endfunction

    task automatic model_reset();
        hist.delete();
        e        = 0;
        m_stable = 4'b0;
        m_prev   = 4'b0;
        for (int n = 0; n < 4; n++) last_flip[n] = 0;
    endtask

    task automatic model_edge(input logic [3:0] b);
        logic [3:0] nxt;
        logic [3:0] smp;
        bit         ok;
        e++;
        hist.push_back(b);
        nxt = m_stable;
        for (int n = 0; n < 4; n++) begin
            ok = 1'b1;
            for (int j = 0; j < int'(DB); j++) begin
                int x;
                x = e - j;
                if (x < 1 || x <= last_flip[n]) begin
                    ok = 1'b0;
                end else begin
                    smp = s2_seen(x);
                    if (smp[n] == m_stable[n]) ok = 1'b0;
                end
            end
            if (ok) begin
                nxt[n]       = ~m_stable[n];
                last_flip[n] = e;
            end
        end
        m_prev   = m_stable;
        m_stable = nxt;
    endtask

    function automatic logic [3:0] moves(logic [3:0] h);
        return {h[3] & ~h[0], h[2] & ~h[1], h[1] & ~h[2], h[0] & ~h[3]};
    endfunction

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    endtask

    task automatic check_model();
        chk("held",    o_held,    m_stable);
        chk("press",   o_press,   m_stable & ~m_prev);
        chk("release", o_release, ~m_stable & m_prev);
        chk("move",    {o_down, o_right, o_left, o_up}, moves(m_stable));
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_held"},    o_held,    4'b0);
        chk({tag, "_press"},   o_press,   4'b0);
        chk({tag, "_release"}, o_release, 4'b0);
        chk({tag, "_move"},    {o_down, o_right, o_left, o_up}, 4'b0);
    endtask

    task automatic tick(input logic [3:0] b);
        i_btn = b;
        @(posedge i_clk);
        model_edge(b);
        #1;
        check_model();
    endtask

    task automatic do_reset(input int ncyc);
        i_rst_n = 1'b0;
        #1;
        check_zero("in_reset");
        repeat (ncyc) @(posedge i_clk);
        #1;
        i_rst_n = 1'b1;
        model_reset();
        #1;
        check_zero("after_release");
    endtask

    logic [3:0] acc;
    logic [3:0] rb;

    initial begin
        i_rst_n = 1'b1;
        i_btn   = 4'b0;
        model_reset();
        #2;
        do_reset(3);

        // Clean press: input up before edge 10, held after edge 15
        repeat (9) tick(4'b0000);
        tick(4'b0001);
        repeat (4) tick(4'b0001);
        chk("press_early", o_held, 4'b0000);
        tick(4'b0001);
        chk("press_held", o_held, 4'b0001);
        chk("press_pulse", o_press, 4'b0001);
        chk("press_up", {o_down, o_right, o_left, o_up}, 4'b0001);
        tick(4'b0001);
        chk("press_once", o_press, 4'b0000);

        // Bounce on left: 3 high, 1 low, 3 high, then low
        acc = 4'b0;
        repeat (3) begin tick(4'b0011); acc |= o_press; end
        tick(4'b0001); acc |= o_press;
        repeat (3) begin tick(4'b0011); acc |= o_press; end
        repeat (8) begin tick(4'b0001); acc |= o_press; end
        chk("bounce_press", acc, 4'b0000);
        chk("bounce_held", o_held & 4'b0010, 4'b0000);

        // Release of right
        repeat (8) tick(4'b0101);
        chk("right_held", o_held, 4'b0101);
        tick(4'b0001);
        repeat (4) tick(4'b0001);
        chk("release_early", o_held, 4'b0101);
        tick(4'b0001);
        chk("release_held", o_held, 4'b0001);
        chk("release_pulse", o_release, 4'b0100);
        chk("release_move", {o_down, o_right, o_left, o_up}, 4'b0001);

        // Up+down cancellation, then release down
        repeat (8) tick(4'b1001);
        chk("cancel_held", o_held, 4'b1001);
        chk("cancel_move", {o_down, o_right, o_left, o_up}, 4'b0000);
        repeat (5) tick(4'b0001);
        chk("uncancel_early", {o_down, o_right, o_left, o_up}, 4'b0000);
        tick(4'b0001);
        chk("uncancel_move", {o_down, o_right, o_left, o_up}, 4'b0001);

        // Reset mid-count on down
        repeat (8) tick(4'b0000);
        repeat (4) tick(4'b1000);
        do_reset(2);
        repeat (5) tick(4'b1000);
        chk("rst_recount_early", o_held, 4'b0000);
        tick(4'b1000);
        chk("rst_recount_held", o_held, 4'b1000);
        chk("rst_recount_press", o_press, 4'b1000);

        // All four together
        repeat (8) tick(4'b0000);
        repeat (5) tick(4'b1111);
        chk("par_early", o_held, 4'b0000);
        tick(4'b1111);
        chk("par_held", o_held, 4'b1111);
        chk("par_press", o_press, 4'b1111);
        chk("par_move", {o_down, o_right, o_left, o_up}, 4'b0000);

        // Random bouncing, alternating busy and quiet segments
        rb = 4'b1111;
        for (int c = 0; c < 1600; c++) begin
            int unsigned p;
            p = ((c / 100) % 2 == 1) ? 20 : 4;
            for (int n = 0; n < 4; n++) begin
                if ($urandom_range(0, p - 1) == 0) rb[n] = ~rb[n];
            end
            tick(rb);
            if (c == 800) do_reset(2);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_btn_conditioner
